mux_16to1: RTL and testbench
============================

# mux_16to1

Registered 16-to-1 single-bit multiplexer. It selects one bit of a 16-bit data word using a 4-bit select and presents it on a registered output, with a combinational copy for same-cycle use. It is the widest member of the team's 2/4/8/16-input mux family and is built as a balanced tree of 2:1 leaf cells, so narrower variants reuse the same leaf.

## Interface
- No parameters: input width is fixed at 16 and select width at 4, both taken from the shared package.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  16  data word; bit a[i] is input channel i.
- s  input  4  select, unsigned binary, 0..15.
- y_comb  output  1  combinational result, a[s].
- y  output  1  registered result, a[s] as sampled at the last rising clk edge.

## Operation
- y_comb = a[s] for every s in 0..15. Unsigned decode: s=0 selects a[0], s=15 selects a[15].
- Tree decode:
  - Level 0: 8 mux2 cells select on s[0]. Cell k chooses a[2k] (s[0]=0) or a[2k+1] (s[0]=1).
  - Level 1: 4 cells select on s[1].
  - Level 2: 2 cells select on s[2].
  - Level 3: 1 cell selects on s[3] and drives y_comb.
- The tree has exactly 15 mux2 instances and no priority logic.
- Every s value is in range, so there is no out-of-range case.
- X/Z handling:
  - If s contains X or Z, y_comb may be X in simulation.
  - If the selected a bit is X, y_comb is X.
  - Unselected a bits never affect the output.
- y register:
  - Loads y_comb on every rising clk edge while rst=0.
  - No enable; it captures every cycle.
- While rst=1, y is held at 0. y_comb is not gated by reset and still follows a and s.

## Timing
- y_comb: zero-cycle, purely combinational path from a and s. Contains no latches.
- y: one-cycle latency. Values of a and s present at rising edge N appear on y after edge N and hold until edge N+1.
- Reset assertion:
  - y goes to 0 immediately and asynchronously, with no clock required.
  - This applies even mid-stream, and discards the captured value.
- Reset release:
  - The first capture happens at the first rising edge with rst=0.
  - y stays 0 until that edge.
- a and s change together: the registered value reflects the pair sampled at the edge, with no mixing across cycles.
- Inputs must meet setup and hold to clk. No handshake.

## Structure
- Shared package mux_pkg holds:
  - constants MUX_N_IN=16 and MUX_SEL_W=4;
  - the narrower family constants (2, 4, 8 inputs with select widths 1, 2, 3).
- One natural sub-module, mux2: inputs d0, d1, sel; output o = sel ? d1 : d0.
- The top module instantiates mux2 fifteen times via a generate loop over the levels, plus one output flop with asynchronous reset.
- Optional intermediate wrappers mux4 and mux8 are built from mux2, for reuse by the narrower family members.

## Test plan
- Reset: assert rst with a=16'hFFFF, s=0 → y=0 immediately, without a clock edge. y_comb=1.
- Directed select on a=16'b1000_1111_1111_1001:
  - s=4'b0011 → y_comb=1, and y=1 after the next edge.
  - s=4'b1111 → 1.
  - s=4'b1100 → 0.
- Walking one: a=1<<i for each i, sweep s over 0..15 → y_comb=1 only when s==i. Repeat with walking zero (inverted).
- Latency: change s every cycle → y equals the previous cycle's y_comb. Check 16 consecutive cycles.
- Mid-stream reset: pulse rst between edges while y=1 → y drops to 0 at once and recaptures a[s] at the first edge after release.
- Exhaustive random: 1000 random (a, s) pairs → y_comb == a[s] each cycle, and y matches the one-cycle-delayed model.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the 2/4/8/16-input single-bit mux family.
// Each member pairs an input count with the select width that addresses it.
package mux_pkg;

  localparam int MUX_N_IN  = 16;
  localparam int MUX_SEL_W = 4;

  localparam int MUX2_N_IN  = 2;
  localparam int MUX2_SEL_W = 1;
  localparam int MUX4_N_IN  = 4;
  localparam int MUX4_SEL_W = 2;
  localparam int MUX8_N_IN  = 8;
  localparam int MUX8_SEL_W = 3;

endpackage

// File: rtl/mux2.sv
// 2:1 single-bit leaf cell shared by every member of the mux family.
module mux2 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic o
);

  assign o = sel ? d1 : d0;

endmodule

// File: rtl/mux_16to1.sv
// Registered 16-to-1 single-bit mux built as a balanced tree of mux2 cells.
// y_comb is the raw tree output; y is its copy captured on each rising clk edge.
module mux_16to1
  import mux_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MUX_N_IN-1:0]  a,
  input  logic [MUX_SEL_W-1:0] s,
  output logic                 y_comb,
  output logic                 y
);

  // Level lvl halves the candidate set using select bit s[lvl]; each level
  // reads the previous level's outputs, so the tree is 8 + 4 + 2 + 1 cells.
  for (genvar lvl = 0; lvl < MUX_SEL_W; lvl++) begin : g_level
    localparam int N_CELLS = MUX_N_IN >> (lvl + 1);

    logic [2*N_CELLS-1:0] level_in;
    logic [N_CELLS-1:0]   level_out;

    if (lvl == 0) begin : g_first
      assign level_in = a;
    end else begin : g_next
      assign level_in = g_level[lvl-1].level_out;
    end

    for (genvar k = 0; k < N_CELLS; k++) begin : g_cell
      mux2 u_mux2 (
        .d0  (level_in[2*k]),
        .d1  (level_in[2*k+1]),
        .sel (s[lvl]),
        .o   (level_out[k])
      );
    end
  end

  assign y_comb = g_level[MUX_SEL_W-1].level_out[0];

  // Reset clears y immediately; y_comb is deliberately left ungated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= 1'b0;
    end else begin
      y <= y_comb;
    end
  end

endmodule

// File: tb/tb_mux_16to1.sv
// Self-checking bench for mux_16to1: directed, walking and random stimulus
// compared against a shift-based reference of a[s] and a one-cycle delayed copy.
module tb_mux_16to1;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [3:0]  s;
  logic        y_comb;
  logic        y;

  int checks = 0;
  int errors = 0;

  mux_16to1 dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .s      (s),
    .y_comb (y_comb),
    .y      (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic refMux(input logic [15:0] word, input logic [3:0] sel);
    logic [15:0] shifted;
    shifted = word >> sel;
    return shifted[0];
  endfunction

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive a pair between edges, check the combinational path, then check y
  // after the edge against the value the pair should have produced.
  task automatic applyStimulus(input logic [15:0] a_v, input logic [3:0] s_v, input string tag);
    logic expected;
    @(negedge clk);
    a = a_v;
    s = s_v;
    expected = refMux(a_v, s_v);
    #1;
    checkOutput({tag, "_comb"}, y_comb, expected);
    @(posedge clk);
    #1;
    checkOutput({tag, "_reg"}, y, expected);
  endtask

  initial begin
    logic [15:0] word;
    logic [3:0]  sel;
    logic        prev_comb;

    rst = 1'b0;
    a   = 16'hFFFF;
    s   = 4'd0;
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_y", y, 1'b0);
    checkOutput("reset_comb", y_comb, 1'b1);

    // Release between edges: y must hold 0 until the first rising edge.
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("release_hold", y, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("first_capture", y, 1'b1);

    applyStimulus(16'b1000_1111_1111_1001, 4'b0011, "dir_s3");
    applyStimulus(16'b1000_1111_1111_1001, 4'b1111, "dir_s15");
    applyStimulus(16'b1000_1111_1111_1001, 4'b1100, "dir_s12");

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        word = 16'd1 << i;
        a = word;
        s = 4'(j);
        #1;
        checkOutput("walk1", y_comb, (i == j));
        a = ~word;
        #1;
        checkOutput("walk0", y_comb, (i != j));
      end
    end

    // s changes every cycle; y must trail y_comb by exactly one cycle.
    word = 16'hA5C3;
    @(negedge clk);
    a = word;
    s = 4'd0;
    for (int i = 1; i <= 16; i++) begin
      prev_comb = refMux(word, 4'(i - 1));
      @(posedge clk);
      #1;
      @(negedge clk);
      s = 4'(i);
      #1;
      checkOutput("latency", y, prev_comb);
    end

    // Pulse reset between edges while y is 1.
    applyStimulus(16'h0010, 4'd4, "pre_pulse");
    #1 rst = 1'b1;
    #1;
    checkOutput("pulse_y", y, 1'b0);
    checkOutput("pulse_comb", y_comb, 1'b1);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("pulse_hold", y, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("pulse_recapture", y, 1'b1);

    for (int n = 0; n < 1000; n++) begin
      word = 16'($urandom);
      sel  = 4'($urandom_range(0, 15));
      applyStimulus(word, sel, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
